regs_wb_queue: RTL

- Buffered writeback front-end that drives the register file's write side.
- Execution stages push single register writes (address and data) through a valid/ready handshake.
- The block retires up to two queued writes per cycle onto the register file's wen/waddr0/wdata0/waddr1/wdata1 port pair, in program order.
- It also reports, for each of the register file's four read addresses, whether that register still has a write pending in the queue, so decode can stall.

---
 rtl/regs_wb_queue_if.sv | 25 ++
 rtl/regs_wb_queue.sv | 137 +++++++++++++
 2 files changed

// File: rtl/regs_wb_queue_if.sv
// Push-side handshake between the execution stages and the writeback queue.
// The execution stage is the master; the queue is the slave.
interface regs_wb_queue_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/regs_wb_queue.sv
// Buffered writeback queue that retires up to two register writes per cycle, in order.
// Optional youngest-match bypass outputs byp0..byp3 are enabled by defining REGS_WB_BYPASS_EN.
module regs_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    regs_wb_queue_if.slave         wb,
    input  logic                   hold,
    output logic                   wen,
    output logic [AW-1:0]          waddr0,
    output logic [DW-1:0]          wdata0,
    output logic [AW-1:0]          waddr1,
    output logic [DW-1:0]          wdata1,
    input  logic [AW-1:0]          raddr0,
    input  logic [AW-1:0]          raddr1,
    input  logic [AW-1:0]          raddr2,
    input  logic [AW-1:0]          raddr3,
    output logic                   pend0,
    output logic                   pend1,
    output logic                   pend2,
    output logic                   pend3,
`ifdef REGS_WB_BYPASS_EN
    output logic [DW-1:0]          byp0,
    output logic [DW-1:0]          byp1,
    output logic [DW-1:0]          byp2,
    output logic [DW-1:0]          byp3,
`endif
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic             w_push;
    logic             w_drain;
    logic [1:0]       w_pop;
    logic [PW-1:0]    w_head1;
    logic             w_two;
    logic [DEPTH-1:0] w_valid;
    logic [AW-1:0]    w_raddr [4];
    logic [3:0]       w_pend;

    assign w_raddr[0] = raddr0;
    assign w_raddr[1] = raddr1;
    assign w_raddr[2] = raddr2;
    assign w_raddr[3] = raddr3;

    // Readiness looks only at pre-pop occupancy, so a full queue never passes through combinationally.
    assign wb.in_ready = !reset && (r_count < CW'(DEPTH));
    assign w_push      = wb.in_valid && wb.in_ready;

    assign w_head1 = r_head + PW'(1);
    assign w_two   = (r_count >= CW'(2));
    assign w_drain = !reset && !hold && (r_count != '0);
    assign w_pop   = !w_drain ? 2'd0 : (w_two ? 2'd2 : 2'd1);

    // A lone entry is presented on both ports so the register file sees a consistent pair.
    assign wen    = w_drain;
    assign waddr0 = r_addr[r_head];
    assign wdata0 = r_data[r_head];
    assign waddr1 = w_two ? r_addr[w_head1] : r_addr[r_head];
    assign wdata1 = w_two ? r_data[w_head1] : r_data[r_head];
    assign count  = r_count;

    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        w_valid = '0;
        w_pend  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, PW'(i) - r_head} < r_count);
        end
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_valid[i] && (r_addr[i] == w_raddr[n])) begin
                    w_pend[n] = 1'b1;
                end
            end
        end
    end

    assign pend0 = w_pend[0];
    assign pend1 = w_pend[1];
    assign pend2 = w_pend[2];
    assign pend3 = w_pend[3];

`ifdef REGS_WB_BYPASS_EN
    logic [DW-1:0] w_byp [4];

    // Walk from oldest to youngest so the last match left standing is the youngest write.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_byp[n] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if ((CW'(k) < r_count) && (r_addr[r_head + PW'(k)] == w_raddr[n])) begin
                    w_byp[n] = r_data[r_head + PW'(k)];
                end
            end
        end
    end

    assign byp0 = w_byp[0];
    assign byp1 = w_byp[1];
    assign byp2 = w_byp[2];
    assign byp3 = w_byp[3];
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            r_head  <= r_head + PW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: entry storage is deliberately not reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= wb.in_addr;
            r_data[r_tail] <= wb.in_data;
        end
    end
endmodule
